// File: rtl/act_wb_pkg.sv
// Shared types and constants for the activation write-back stage.
// The optional ping-pong capture path is enabled by ACT_WB_DOUBLE_BUF_EN.
package act_wb_pkg;

    localparam int DATA_WIDTH = 11;
    localparam int SA_LENGTH  = 256;
    localparam int LANES      = 16;
    localparam int ADDR_WIDTH = 16;
    localparam int NUM_BEATS  = SA_LENGTH / LANES;
    localparam int BEAT_CNT_W = $clog2(NUM_BEATS);
    localparam int LANE_W     = $clog2(LANES);

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(NUM_BEATS - 1);

    typedef logic signed [DATA_WIDTH-1:0] elem_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_t;

endpackage

// File: rtl/act_writeback_if.sv
// Capture-side and write-port signals of act_writeback, grouped as one bus.
// The optional double-buffer build (ACT_WB_DOUBLE_BUF_EN) uses the same bus.
interface act_writeback_if;
    import act_wb_pkg::*;

    logic                        in_valid;
    logic                        in_ready;
    elem_t                       in [SA_LENGTH];
    logic [ADDR_WIDTH-1:0]       base_addr;
    logic                        wr_valid;
    logic                        wr_ready;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [LANES*DATA_WIDTH-1:0] wr_data;
    logic                        wr_last;

    modport master (
        output in_valid, in, base_addr, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data, wr_last
    );

    modport slave (
        input  in_valid, in, base_addr, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data, wr_last
    );

endinterface

// File: rtl/act_wb_lane_select.sv
// Picks the LANES elements of beat 'beat' from a vector and packs them,
// element k at bits [k*DATA_WIDTH +: DATA_WIDTH]. Purely combinational.
module act_wb_lane_select
    import act_wb_pkg::*;
(
    input  elem_t                       vec [SA_LENGTH],
    input  logic [BEAT_CNT_W-1:0]       beat,
    output logic [LANES*DATA_WIDTH-1:0] data
);

    // Element index is {beat, lane}, so no multiplier is needed.
    always_comb begin
        data = '0;
        for (int k = 0; k < LANES; k++) begin
            logic [BEAT_CNT_W+LANE_W-1:0] idx;
            idx = {beat, LANE_W'(k)};
            data[k*DATA_WIDTH +: DATA_WIDTH] = vec[idx];
        end
    end

endmodule

// File: rtl/act_writeback.sv
// Captures activation vectors and drains them as LANES-wide addressed beats.
// Define ACT_WB_DOUBLE_BUF_EN for ping-pong capture buffers (no dead cycle).
module act_writeback
    import act_wb_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    act_writeback_if.slave bus,
    output logic           busy
);

    state_t                      state_q, state_d;
    logic [BEAT_CNT_W-1:0]       beat_q, beat_d;
    logic                        capture_s, accept_s, last_s;
    logic [ADDR_WIDTH-1:0]       cur_base_s;
    logic [LANES*DATA_WIDTH-1:0] sel_data_s;
    elem_t                       rd_vec_s [SA_LENGTH];

    assign capture_s = bus.in_valid & bus.in_ready;
    assign accept_s  = bus.wr_valid & bus.wr_ready;
    assign last_s    = (beat_q == LAST_BEAT);

`ifdef ACT_WB_DOUBLE_BUF_EN
    logic [1:0]            full_q, full_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  cap_ptr_s;
    logic [ADDR_WIDTH-1:0] base_q [2];
    logic [ADDR_WIDTH-1:0] base_d [2];
    elem_t                 buf_q [2][SA_LENGTH];
    elem_t                 buf_d [2][SA_LENGTH];

    // in_ready comes from registered full flags, so a buffer freed this cycle is not refilled this cycle.
    assign bus.in_ready = ~(&full_q);
    assign busy         = |full_q;
    assign cap_ptr_s    = full_q[rd_ptr_q] ? ~rd_ptr_q : rd_ptr_q;
    assign cur_base_s   = base_q[rd_ptr_q];
    assign rd_vec_s     = buf_q[rd_ptr_q];

    // Next-state: release the draining buffer on its last beat, fill the free one on capture.
    always_comb begin
        full_d   = full_q;
        rd_ptr_d = rd_ptr_q;
        beat_d   = beat_q;
        base_d   = base_q;
        buf_d    = buf_q;
        state_d  = state_q;
        if (accept_s && last_s) begin
            full_d[rd_ptr_q] = 1'b0;
            rd_ptr_d         = ~rd_ptr_q;
            beat_d           = '0;
        end else if (accept_s) begin
            beat_d = beat_q + BEAT_CNT_W'(1);
        end else begin
            beat_d = beat_q;
        end
        if (capture_s) begin
            full_d[cap_ptr_s] = 1'b1;
            base_d[cap_ptr_s] = bus.base_addr;
            buf_d[cap_ptr_s]  = bus.in;
        end else begin
            base_d = base_q;
        end
        case (state_q)
            IDLE:    state_d = capture_s ? DRAIN : IDLE;
            DRAIN:   state_d = (|full_d) ? DRAIN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Buffer-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_q   <= 2'b00;
            rd_ptr_q <= 1'b0;
        end else begin
            full_q   <= full_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Captured payload; validity is tracked by full_q alone.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        buf_q  <= buf_d;
    end
`else
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    elem_t                 buf_q [SA_LENGTH];
    elem_t                 buf_d [SA_LENGTH];

    assign bus.in_ready = (state_q == IDLE);
    assign busy         = (state_q == DRAIN);
    assign cur_base_s   = base_q;
    assign rd_vec_s     = buf_q;

    // Next-state: capture in IDLE, step beats in DRAIN, return to IDLE after the last beat.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        base_d  = base_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    state_d = DRAIN;
                    beat_d  = '0;
                    base_d  = bus.base_addr;
                    buf_d   = bus.in;
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                if (accept_s && last_s) begin
                    state_d = IDLE;
                    beat_d  = '0;
                end else if (accept_s) begin
                    beat_d = beat_q + BEAT_CNT_W'(1);
                end else begin
                    state_d = DRAIN;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Captured payload; meaningful only while DRAIN.
    always_ff @(posedge clk) begin
        base_q <= base_d;
        buf_q  <= buf_d;
    end
`endif

    // FSM state and beat counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    act_wb_lane_select u_lane_select (
        .vec  (rd_vec_s),
        .beat (beat_q),
        .data (sel_data_s)
    );

    // Write port is decoded from registers only; outputs read zero outside DRAIN.
    always_comb begin
        bus.wr_valid = 1'b0;
        bus.wr_last  = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        if (state_q == DRAIN) begin
            bus.wr_valid = 1'b1;
            bus.wr_last  = last_s;
            bus.wr_addr  = cur_base_s + ADDR_WIDTH'(beat_q);
            bus.wr_data  = sel_data_s;
        end else begin
            bus.wr_valid = 1'b0;
        end
    end

endmodule
